// File: rtl/dcmac_0_pkt_mon_stats_pkg.sv
// Shared register map, FSM states and per-ID shadow layout for the
// packet-monitor statistics register block.
package dcmac_0_pkt_mon_stats_pkg;

  localparam logic [5:0] OFF_CTRL     = 6'h00;
  localparam logic [5:0] OFF_STATUS   = 6'h04;
  localparam logic [5:0] OFF_PKT_LO   = 6'h08;
  localparam logic [5:0] OFF_PKT_HI   = 6'h0C;
  localparam logic [5:0] OFF_BYTE_LO  = 6'h10;
  localparam logic [5:0] OFF_BYTE_HI  = 6'h14;
  localparam logic [5:0] OFF_PRBS_ERR = 6'h18;
  localparam logic [5:0] OFF_SNAP_CNT = 6'h1C;

  localparam int unsigned GLOBAL_ADDR = 32'h800;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  typedef struct packed {
    logic [63:0] pkt;
    logic [63:0] bytes;
    logic [31:0] prbs_err;
    logic [31:0] snap_cnt;
    logic        lock_lost;
    logic        ever_locked;
    logic        locked_q;
  } shadow_t;

endpackage

// File: rtl/dcmac_0_pkt_mon_stats_shadow.sv
// One stream ID's snapshot registers, snapshot counter and sticky PRBS lock
// history. A set event in the same cycle as a W1C keeps the bit set.
module dcmac_0_pkt_mon_stats_shadow
  import dcmac_0_pkt_mon_stats_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pkt_cnt,
  input  logic [63:0] byte_cnt,
  input  logic [31:0] prbs_err_cnt,
  input  logic        prbs_locked,
  input  logic        snap,
  input  logic        w1c_lock_lost,
  input  logic        w1c_ever_locked,
  output shadow_t     shadow
);

  shadow_t shadow_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_reg <= '0;
    end else begin
      if (snap) begin
        shadow_reg.pkt      <= pkt_cnt;
        shadow_reg.bytes    <= byte_cnt;
        shadow_reg.prbs_err <= prbs_err_cnt;
        shadow_reg.snap_cnt <= shadow_reg.snap_cnt + 32'd1;
      end
      shadow_reg.locked_q    <= prbs_locked;
      shadow_reg.lock_lost   <= (shadow_reg.lock_lost & ~w1c_lock_lost)
                              | (shadow_reg.locked_q & ~prbs_locked);
      shadow_reg.ever_locked <= (shadow_reg.ever_locked & ~w1c_ever_locked)
                              | prbs_locked;
    end
  end

  assign shadow = shadow_reg;

endmodule

// File: rtl/dcmac_0_pkt_mon_stats_regs.sv
// Software register front end for the per-ID packet/PRBS monitor: single
// outstanding request FSM, address decode, read mux and counter-clear pulses.
module dcmac_0_pkt_mon_stats_regs
  import dcmac_0_pkt_mon_stats_pkg::*;
#(
  parameter int NUM_ID = 6,
  parameter int ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_ID*64-1:0] i_pkt_cnt,
  input  logic [NUM_ID*64-1:0] i_byte_cnt,
  input  logic [NUM_ID*32-1:0] i_prbs_err_cnt,
  input  logic [NUM_ID-1:0]    i_prbs_locked,
  output logic [NUM_ID-1:0]    o_clear_counters,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_wr,
  input  logic [ADDR_W-1:0]    i_req_addr,
  input  logic [31:0]          i_req_wdata,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [31:0]          o_rsp_rdata,
  output logic                 o_rsp_err
);

  localparam int ID_W = ADDR_W - 6;

  state_t              state_reg, state_next;
  logic                req_wr_reg;
  logic [ADDR_W-1:2]   req_addr_reg;
  logic [2:0]          req_wdata_reg;
  logic                rsp_valid_reg, rsp_err_reg;
  logic [31:0]         rsp_rdata_reg;
  logic [NUM_ID-1:0]   clear_reg;
  logic                accept, exec_state;

  shadow_t             shadow [NUM_ID];
  shadow_t             sel_shadow;
  logic                sel_locked, is_global, dec_err;
  logic [NUM_ID-1:0]   hit_id, snap_mask, clear_mask, w1c_lost_mask, w1c_ever_mask;
  logic [5:0]          off;
  logic [31:0]         rd_data;
  logic                unused_bits;

  assign unused_bits = ^{i_req_wdata[31:3], i_req_addr[1:0], sel_shadow.locked_q};

  assign o_req_ready = (state_reg == IDLE) && !rst;
  assign accept      = i_req_valid && o_req_ready;
  assign exec_state  = (state_reg == EXEC);

  for (genvar gi = 0; gi < NUM_ID; gi++) begin : g_shadow
    dcmac_0_pkt_mon_stats_shadow u_shadow (
      .clk             (clk),
      .rst             (rst),
      .pkt_cnt         (i_pkt_cnt[gi*64 +: 64]),
      .byte_cnt        (i_byte_cnt[gi*64 +: 64]),
      .prbs_err_cnt    (i_prbs_err_cnt[gi*32 +: 32]),
      .prbs_locked     (i_prbs_locked[gi]),
      .snap            (exec_state & snap_mask[gi]),
      .w1c_lock_lost   (exec_state & w1c_lost_mask[gi]),
      .w1c_ever_locked (exec_state & w1c_ever_mask[gi]),
      .shadow          (shadow[gi])
    );
  end

  always_comb begin
    hit_id     = '0;
    sel_shadow = '0;
    sel_locked = 1'b0;
    for (int i = 0; i < NUM_ID; i++) begin
      hit_id[i] = (req_addr_reg[ADDR_W-1:6] == ID_W'(i));
      if (hit_id[i]) begin
        sel_shadow = shadow[i];
        sel_locked = i_prbs_locked[i];
      end
    end
  end

  // Masks are only acted on in EXEC; decode runs off the captured request.
  always_comb begin
    is_global     = ({req_addr_reg, 2'b00} == ADDR_W'(GLOBAL_ADDR));
    off           = {req_addr_reg[5:2], 2'b00};
    rd_data       = '0;
    dec_err       = 1'b1;
    snap_mask     = '0;
    clear_mask    = '0;
    w1c_lost_mask = '0;
    w1c_ever_mask = '0;
    if (is_global) begin
      if (req_wr_reg) begin
        dec_err    = 1'b0;
        snap_mask  = {NUM_ID{req_wdata_reg[0]}};
        clear_mask = {NUM_ID{req_wdata_reg[1]}};
      end
    end else if (|hit_id) begin
      case (off)
        OFF_CTRL: begin
          dec_err = 1'b0;
          if (req_wr_reg) begin
            snap_mask  = hit_id & {NUM_ID{req_wdata_reg[0]}};
            clear_mask = hit_id & {NUM_ID{req_wdata_reg[1]}};
          end
        end
        OFF_STATUS: begin
          dec_err = 1'b0;
          if (req_wr_reg) begin
            w1c_lost_mask = hit_id & {NUM_ID{req_wdata_reg[1]}};
            w1c_ever_mask = hit_id & {NUM_ID{req_wdata_reg[2]}};
          end else begin
            rd_data = {29'd0, sel_shadow.ever_locked, sel_shadow.lock_lost, sel_locked};
          end
        end
        OFF_PKT_LO, OFF_PKT_HI, OFF_BYTE_LO, OFF_BYTE_HI, OFF_PRBS_ERR, OFF_SNAP_CNT: begin
          dec_err = req_wr_reg;
          if (!req_wr_reg) begin
            case (off)
              OFF_PKT_LO:   rd_data = sel_shadow.pkt[31:0];
              OFF_PKT_HI:   rd_data = sel_shadow.pkt[63:32];
              OFF_BYTE_LO:  rd_data = sel_shadow.bytes[31:0];
              OFF_BYTE_HI:  rd_data = sel_shadow.bytes[63:32];
              OFF_PRBS_ERR: rd_data = sel_shadow.prbs_err;
              default:      rd_data = sel_shadow.snap_cnt;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_valid_reg && i_rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      req_wr_reg    <= 1'b0;
      req_addr_reg  <= '0;
      req_wdata_reg <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      clear_reg     <= '0;
    end else begin
      state_reg <= state_next;
      clear_reg <= '0;
      if (accept) begin
        req_wr_reg    <= i_req_wr;
        req_addr_reg  <= i_req_addr[ADDR_W-1:2];
        req_wdata_reg <= i_req_wdata[2:0];
      end
      if (exec_state) begin
        rsp_valid_reg <= 1'b1;
        rsp_rdata_reg <= rd_data;
        rsp_err_reg   <= dec_err;
        clear_reg     <= clear_mask;
      end else if (rsp_valid_reg && i_rsp_ready) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  assign o_rsp_valid      = rsp_valid_reg;
  assign o_rsp_rdata      = rsp_rdata_reg;
  assign o_rsp_err        = rsp_err_reg;
  assign o_clear_counters = clear_reg;

endmodule

// File: tb/tb_dcmac_0_pkt_mon_stats_regs.sv
// Bench for the stats register block: directed cases plus randomized
// register traffic scored against an array-based model of the register map.
module tb_dcmac_0_pkt_mon_stats_regs;

  localparam int NUM_ID = 6;
  localparam int ADDR_W = 12;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_ID*64-1:0] i_pkt_cnt, i_byte_cnt;
  logic [NUM_ID*32-1:0] i_prbs_err_cnt;
  logic [NUM_ID-1:0]    i_prbs_locked;
  logic [NUM_ID-1:0]    o_clear_counters;
  logic                 i_req_valid, o_req_ready, i_req_wr;
  logic [ADDR_W-1:0]    i_req_addr;
  logic [31:0]          i_req_wdata;
  logic                 o_rsp_valid, i_rsp_ready, o_rsp_err;
  logic [31:0]          o_rsp_rdata;

  always #5 clk = ~clk;

  dcmac_0_pkt_mon_stats_regs #(.NUM_ID(NUM_ID), .ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_pkt_cnt        (i_pkt_cnt),
    .i_byte_cnt       (i_byte_cnt),
    .i_prbs_err_cnt   (i_prbs_err_cnt),
    .i_prbs_locked    (i_prbs_locked),
    .o_clear_counters (o_clear_counters),
    .i_req_valid      (i_req_valid),
    .o_req_ready      (o_req_ready),
    .i_req_wr         (i_req_wr),
    .i_req_addr       (i_req_addr),
    .i_req_wdata      (i_req_wdata),
    .o_rsp_valid      (o_rsp_valid),
    .i_rsp_ready      (i_rsp_ready),
    .o_rsp_rdata      (o_rsp_rdata),
    .o_rsp_err        (o_rsp_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit lock_rand = 1'b0;

  logic [63:0] m_pkt  [NUM_ID];
  logic [63:0] m_byte [NUM_ID];
  logic [31:0] m_prbs [NUM_ID];
  logic [31:0] m_cnt  [NUM_ID];
  bit          m_lost [NUM_ID];
  bit          m_ever [NUM_ID];
  bit          m_prev [NUM_ID];

  logic [31:0]       last_rd;
  logic              last_err;
  logic [NUM_ID-1:0] last_clear;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_ID; i++) begin
      m_pkt[i] = '0; m_byte[i] = '0; m_prbs[i] = '0; m_cnt[i] = '0;
      m_lost[i] = 1'b0; m_ever[i] = 1'b0; m_prev[i] = 1'b0;
    end
  endtask

  // One clock: W1C first, then this cycle's lock events (set wins).
  task automatic tick(input logic [NUM_ID-1:0] clr_lost, input logic [NUM_ID-1:0] clr_ever);
    logic [NUM_ID-1:0] lk;
    int k;
    lk = i_prbs_locked;
    @(posedge clk);
    for (int i = 0; i < NUM_ID; i++) begin
      if (clr_lost[i]) m_lost[i] = 1'b0;
      if (clr_ever[i]) m_ever[i] = 1'b0;
      if (m_prev[i] && !lk[i]) m_lost[i] = 1'b1;
      if (lk[i]) m_ever[i] = 1'b1;
      m_prev[i] = lk[i];
    end
    #1;
    if (lock_rand && $urandom_range(0, 3) == 0) begin
      k = $urandom_range(0, NUM_ID - 1);
      i_prbs_locked[k] = ~i_prbs_locked[k];
    end
  endtask

  task automatic model_eval(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output bit err,
                            output logic [NUM_ID-1:0] snap, output logic [NUM_ID-1:0] clr,
                            output logic [NUM_ID-1:0] lostc, output logic [NUM_ID-1:0] everc);
    int a, id, off;
    a = int'(addr) & ~3;
    rd = '0; err = 1'b1; snap = '0; clr = '0; lostc = '0; everc = '0;
    if (a == 'h800) begin
      if (wr) begin
        err = 1'b0;
        if (wd[0]) snap = '1;
        if (wd[1]) clr = '1;
      end
    end else begin
      id  = a / 64;
      off = a % 64;
      if (id < NUM_ID) begin
        case (off)
          0: begin
            err = 1'b0;
            if (wr) begin snap[id] = wd[0]; clr[id] = wd[1]; end
          end
          4: begin
            err = 1'b0;
            if (wr) begin lostc[id] = wd[1]; everc[id] = wd[2]; end
            else rd = {29'd0, m_ever[id], m_lost[id], i_prbs_locked[id]};
          end
          8, 12, 16, 20, 24, 28: begin
            if (!wr) begin
              err = 1'b0;
              case (off)
                8:  rd = m_pkt[id][31:0];
                12: rd = m_pkt[id][63:32];
                16: rd = m_byte[id][31:0];
                20: rd = m_byte[id][63:32];
                24: rd = m_prbs[id];
                default: rd = m_cnt[id];
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic do_txn(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                        input int stall, input logic [NUM_ID-1:0] flip);
    logic [31:0] e_rd;
    bit e_err;
    logic [NUM_ID-1:0] sm, cm, lm, em;
    int n;
    i_req_valid = 1'b1; i_req_wr = wr; i_req_addr = addr; i_req_wdata = wd;
    n = 0;
    while (!o_req_ready && n < 20) begin tick('0, '0); n++; end
    chk("req_ready_idle", o_req_ready, 1);
    tick('0, '0);
    i_req_valid = 1'b0; i_req_wr = 1'b0; i_req_addr = ADDR_W'($urandom); i_req_wdata = $urandom;
    chk("ready_low_exec", o_req_ready, 0);
    chk("rsp_valid_exec", o_rsp_valid, 0);
    i_prbs_locked = i_prbs_locked ^ flip;
    model_eval(wr, addr, wd, e_rd, e_err, sm, cm, lm, em);
    for (int i = 0; i < NUM_ID; i++) begin
      if (sm[i]) begin
        m_pkt[i]  = i_pkt_cnt[i*64 +: 64];
        m_byte[i] = i_byte_cnt[i*64 +: 64];
        m_prbs[i] = i_prbs_err_cnt[i*32 +: 32];
        m_cnt[i]  = m_cnt[i] + 32'd1;
      end
    end
    if (stall > 0) i_rsp_ready = 1'b0;
    tick(lm, em);
    chk("rsp_valid", o_rsp_valid, 1);
    chk("rsp_rdata", o_rsp_rdata, e_rd);
    chk("rsp_err", o_rsp_err, e_err);
    chk("clear_pulse", o_clear_counters, cm);
    last_rd = o_rsp_rdata; last_err = o_rsp_err; last_clear = o_clear_counters;
    $display("[TB] %s addr=0x%03h wdata=0x%08h rdata=0x%08h err=%0d clear=%b stall=%0d",
             wr ? "WR" : "RD", addr, wd, o_rsp_rdata, o_rsp_err, o_clear_counters, stall);
    for (int s = 0; s < stall; s++) begin
      tick('0, '0);
      chk("stall_valid", o_rsp_valid, 1);
      chk("stall_rdata", o_rsp_rdata, e_rd);
      chk("stall_ready", o_req_ready, 0);
      chk("stall_clear", o_clear_counters, 0);
    end
    i_rsp_ready = 1'b1;
    tick('0, '0);
    chk("rsp_done", o_rsp_valid, 0);
    chk("clear_done", o_clear_counters, 0);
    chk("ready_again", o_req_ready, 1);
  endtask

  task automatic randomize_live();
    for (int i = 0; i < NUM_ID; i++) begin
      i_pkt_cnt[i*64 +: 64]      = {$urandom, $urandom};
      i_byte_cnt[i*64 +: 64]     = {$urandom, $urandom};
      i_prbs_err_cnt[i*32 +: 32] = $urandom;
    end
  endtask

  initial begin
    logic [31:0] e_rd, held;
    bit e_err;
    logic [NUM_ID-1:0] sm, cm, lm, em;
    logic [11:0] addr;

    rst = 1'b1; i_req_valid = 1'b0; i_req_wr = 1'b0; i_req_addr = '0; i_req_wdata = '0;
    i_rsp_ready = 1'b1; i_prbs_locked = '0;
    randomize_live();
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", o_req_ready, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_rdata", o_rsp_rdata, 0);
    chk("rst_err", o_rsp_err, 0);
    chk("rst_clear", o_clear_counters, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", o_req_ready, 1);

    do_txn(0, 12'h004, 0, 0, '0);
    chk("status0_reset", last_rd, 32'h0);

    // Coherent 64-bit snapshot
    i_pkt_cnt[2*64 +: 64] = 64'h0000_0001_FFFF_FFFF;
    do_txn(1, 12'h080, 32'h1, 0, '0);
    i_pkt_cnt[2*64 +: 64] = 64'h0000_0005_0000_0007;
    do_txn(0, 12'h088, 0, 0, '0);
    chk("pkt2_lo", last_rd, 32'hFFFF_FFFF);
    do_txn(0, 12'h08C, 0, 0, '0);
    chk("pkt2_hi", last_rd, 32'h1);
    do_txn(0, 12'h09C, 0, 0, '0);
    chk("snapcnt2", last_rd, 32'h1);

    // SNAP+CLEAR
    i_byte_cnt[1*64 +: 64] = 64'h1234;
    do_txn(1, 12'h040, 32'h3, 0, '0);
    chk("clear_id1", last_clear, 6'b000010);
    do_txn(0, 12'h050, 0, 0, '0);
    chk("byte1_lo", last_rd, 32'h1234);

    // Lock-lost set in the same cycle as its W1C
    i_prbs_locked[3] = 1'b1;
    tick('0, '0); tick('0, '0);
    do_txn(1, 12'h0C4, 32'h2, 0, 6'b001000);
    do_txn(0, 12'h0C4, 0, 0, '0);
    chk("status3_setwins", last_rd, 32'h6);
    do_txn(1, 12'h0C4, 32'h2, 0, '0);
    do_txn(0, 12'h0C4, 0, 0, '0);
    chk("status3_w1c", last_rd, 32'h4);

    // Decode errors
    do_txn(0, 12'h180, 0, 0, '0);
    chk("err_id6", last_err, 1);
    do_txn(1, 12'h008, 32'hDEAD_BEEF, 0, '0);
    chk("err_wr_ro", last_err, 1);
    do_txn(0, 12'h800, 0, 0, '0);
    chk("err_rd_global", last_err, 1);
    do_txn(0, 12'h088, 0, 2, '0);
    chk("pkt2_unchanged", last_rd, 32'hFFFF_FFFF);

    // Stalled response, then reset mid-transaction
    i_req_valid = 1'b1; i_req_wr = 1'b0; i_req_addr = 12'h09C;
    tick('0, '0);
    i_req_valid = 1'b0;
    model_eval(0, 12'h09C, 0, e_rd, e_err, sm, cm, lm, em);
    i_rsp_ready = 1'b0;
    tick('0, '0);
    held = o_rsp_rdata;
    chk("hold_first_valid", o_rsp_valid, 1);
    chk("hold_first_rdata", held, e_rd);
    for (int c = 0; c < 2; c++) begin
      tick('0, '0);
      chk("hold_valid", o_rsp_valid, 1);
      chk("hold_rdata", o_rsp_rdata, e_rd);
      chk("hold_ready", o_req_ready, 0);
    end
    rst = 1'b1;
    tick('0, '0);
    chk("midrst_valid", o_rsp_valid, 0);
    chk("midrst_ready", o_req_ready, 0);
    rst = 1'b0; i_rsp_ready = 1'b1;
    model_reset();
    #1;
    chk("midrst_idle", o_req_ready, 1);
    $display("[TB] RD addr=0x09C stalled then reset, held rdata=0x%08h", held);
    do_txn(0, 12'h09C, 0, 0, '0);
    chk("snapcnt_after_rst", last_rd, 32'h0);

    // Randomized traffic
    lock_rand = 1'b1;
    for (int t = 0; t < 80; t++) begin
      randomize_live();
      if ($urandom_range(0, 9) == 0)
        addr = 12'h800 | 12'($urandom_range(0, 3));
      else
        addr = 12'($urandom_range(0, 7) * 64 + $urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      do_txn(1'($urandom_range(0, 1)), addr, $urandom, $urandom_range(0, 3), '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
